// File: rtl/csi_rx_raw_unpack_if.sv
// Payload-in / pixel-out bundle between the CSI-2 packet handler and the RAW unpacker.
// The slave side is the unpacker; the master side is whoever feeds payload and consumes pixels.
interface csi_rx_raw_unpack_if;
    logic [31:0] payload;
    logic        payload_enable;
    logic        payload_frame;
    logic [39:0] pixel_data;
    logic        pixel_enable;
    logic        pixel_frame;
    logic        partial_drop;

    modport master (
        output payload, payload_enable, payload_frame,
        input  pixel_data, pixel_enable, pixel_frame, partial_drop
    );

    modport slave (
        input  payload, payload_enable, payload_frame,
        output pixel_data, pixel_enable, pixel_frame, partial_drop
    );
endinterface

// File: rtl/csi_rx_raw_unpack.sv
// Unpacks 32-bit CSI-2 payload words into 4-pixel groups of 10-bit pixels.
// RAW10 reassembles 5-byte groups across word boundaries; RAW8 widens each byte.
module csi_rx_raw_unpack #(
    parameter bit RAW10 = 1'b1
) (
    input logic           clock,
    input logic           reset,
    input logic           enable,
    csi_rx_raw_unpack_if.slave bus
);

    logic [31:0] byte_buf_q;
    logic [2:0]  count_q;
    logic        frame_q;
    logic [39:0] data_q;
    logic        pixel_en_q;
    logic        drop_q;

    logic        accept;
    logic [63:0] merged;
    logic [39:0] raw10_pix;
    logic [39:0] raw8_pix;

    assign accept = bus.payload_enable && bus.payload_frame;

    // New bytes land directly after the buffered ones; the oldest five form a group.
    assign merged = {32'b0, byte_buf_q} | ({32'b0, bus.payload} << {count_q, 3'b000});

    always_comb begin
        raw10_pix = '0;
        raw8_pix  = '0;
        for (int i = 0; i < 4; i++) begin
            raw10_pix[10*i +: 10] = {merged[8*i +: 8], merged[32 + 2*i +: 2]};
            raw8_pix[10*i +: 10]  = {bus.payload[8*i +: 8], 2'b00};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_buf_q <= '0;
            count_q    <= '0;
            frame_q    <= 1'b0;
            data_q     <= '0;
            pixel_en_q <= 1'b0;
            drop_q     <= 1'b0;
        end else if (enable) begin
            frame_q    <= bus.payload_frame;
            pixel_en_q <= 1'b0;
            drop_q     <= 1'b0;
            // Outside a frame the buffer is flushed so the next frame starts at byte 0.
            if (!bus.payload_frame) begin
                byte_buf_q <= '0;
                count_q    <= '0;
                drop_q     <= frame_q && (count_q != 3'd0);
            end else if (accept) begin
                if (RAW10) begin
                    if (count_q != 3'd0) begin
                        data_q     <= raw10_pix;
                        pixel_en_q <= 1'b1;
                        byte_buf_q <= {8'b0, merged[63:40]};
                        count_q    <= count_q - 3'd1;
                    end else begin
                        byte_buf_q <= bus.payload;
                        count_q    <= 3'd4;
                    end
                end else begin
                    data_q     <= raw8_pix;
                    pixel_en_q <= 1'b1;
                end
            end
        end
    end

    assign bus.pixel_data   = data_q;
    assign bus.pixel_enable = pixel_en_q;
    assign bus.pixel_frame  = frame_q;
    assign bus.partial_drop = drop_q;

endmodule

// File: doc/csi_rx_raw_unpack.md
Name: csi_rx_raw_unpack

Overview:
Sits directly downstream of the CSI-2 packet handler. Consumes its 32-bit little-endian payload word stream (payload / payload_enable / payload_frame) and unpacks it into groups of four pixels. RAW10 mode reassembles 5-byte packed groups, carrying bytes across word boundaries. RAW8 mode widens bytes to 10 bits.

Parameters:
RAW10, default 1, 1 = unpack RAW10 (5 bytes -> 4 pixels); 0 = RAW8 (4 bytes -> 4 pixels, pixel = {byte, 2'b00})

Ports:
clock  input  1  byte/word clock
reset  input  1  active-high synchronous reset
enable  input  1  active-high clock enable; when low, all state and outputs hold
payload  input  32  payload word; byte k = payload[8k+7:8k], byte 0 first on the wire
payload_enable  input  1  payload word valid
payload_frame  input  1  high for the duration of a long-packet payload
pixel_data  output  40  four pixels; pixel i = pixel_data[10i+9:10i], pixel 0 earliest
pixel_enable  output  1  pixel_data valid (1-cycle pulse per group)
pixel_frame  output  1  payload_frame delayed by one enabled cycle
partial_drop  output  1  1-cycle pulse: frame ended with leftover unconsumed bytes

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high. On reset: pixel_data=0, pixel_enable=0, pixel_frame=0, partial_drop=0, byte count=0, byte buffer=0.
- All register updates are qualified by enable.
- Internal state: byte buffer, at most 8 bytes, plus byte count c (0..4 between cycles).
- Word accept: a word is accepted when payload_enable && payload_frame.
  - payload_enable while payload_frame is low is ignored.
- RAW10 mode, on accept:
  - The four new bytes are appended after the c buffered bytes, giving c+4 bytes.
  - If c+4 >= 5: the oldest 5 bytes b0..b4 form a group, and the remaining c-1 bytes shift to the head.
    - Pixel i = {b_i, b4[2i+1:2i]} for i = 0..3.
    - pixel_enable pulses on the next cycle with that group on pixel_data.
  - Otherwise the bytes are retained (c becomes 4).
- RAW10 steady-state pattern from c=0: 5 accepted words -> 4 groups. Counts go 0 -> 4 -> 3 -> 2 -> 1 -> 0.
  - At most one group is produced per accept, so no backpressure is needed.
- RAW8 mode, on accept: pixel i = {byte_i, 2'b00}; pixel_enable pulses next cycle. c is always 0.
- Latency: one cycle from the completing accepted word to pixel_enable.
- pixel_data holds its last value when pixel_enable is low.
- Frame end (registered payload_frame 1 -> 0):
  - If c != 0, partial_drop pulses on the following cycle.
  - c is cleared in both cases; leftover bytes are discarded and never emitted.
- While payload_frame is low, c is held at 0.
  - The next frame therefore always starts aligned at byte 0.
- Simultaneous case: an accepted word on the last frame cycle is unpacked normally. The drop check uses the count after that word.
- Reset mid-frame: everything clears. Unpacking restarts on the next accepted word; c=0 is treated as group-aligned.
- enable low mid-frame: the count, buffer and pending output are frozen and resume unchanged when enable returns high.

Test Plan:
- RAW10, one frame of 5 words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, 0x13121110 -> exactly 4 pixel_enable pulses, no partial_drop.
  - Group 0 pixels = 0x000, 0x005, 0x008, 0x00C; each pulse is 1 cycle after the completing word.
- RAW10, all bytes 0xFF for 10 words -> 8 pulses, each pixel = 0x3FF, partial_drop never asserted.
- RAW10, frame of 3 words of 0xFF -> 2 pulses, then partial_drop pulses once after payload_frame falls.
  - The next frame's first group starts from its own byte 0.
- RAW8 (RAW10=0), word 0x80FF0100 -> one pulse, 1 cycle later, with pixels 0x000, 0x004, 0x3FC, 0x200.
- Gaps and enable: payload_enable deasserted for 3 cycles between words, plus enable low for 2 cycles mid-group -> identical pixel values to the gapless run, with pulses shifted accordingly.
- Reset asserted after 2 RAW10 words -> all outputs 0 next cycle, no pulse or partial_drop.
  - A following 5-word frame unpacks correctly.
